// File: rtl/spi_dev_lcdpalrd.sv
// rtl/spi_dev_lcdpalrd.sv - SPI palette RAM readback device; macro SPI_DEV_LCDPALRD_PREFETCH_EN selects the two-entry prefetch build
module spi_dev_lcdpalrd #(
    parameter logic [7:0] CMD_BYTE = 8'he6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  pw_wdata,
    input  logic        pw_wcmd,
    input  logic        pw_wstb,
    output logic [7:0]  pw_rdata,
    input  logic        pw_rstb,
    input  logic        pw_end,
    output logic [7:0]  pal_raddr,
    output logic        pal_ren,
    input  logic        pal_rgnt,
    input  logic [15:0] pal_rdata
);

`ifdef SPI_DEV_LCDPALRD_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IDX  = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  idx_q, idx_d;           // next palette index to request, doubles as pal_raddr
    logic        ren_q, ren_d;
    logic        inflight_q, inflight_d; // a granted entry returns on pal_rdata this cycle
    logic        bsel_q, bsel_d;
    logic [1:0]  cnt_q, cnt_d;           // valid entries, ent_q[0] is the head
    logic [2:0]  drop_q, drop_d;         // future arrivals already retired by underflow reads
    logic [15:0] ent_q [DEPTH];
    logic [15:0] ent_d [DEPTH];
    logic        grant;

    assign grant     = ren_q & pal_rgnt;
    assign pal_ren   = ren_q;
    assign pal_raddr = idx_q;

    // Read byte: head entry split by bsel; zero when idle or underflowing so devices can be OR-ed
    assign pw_rdata = (state_q == ST_RUN && cnt_q != 2'd0)
                    ? (bsel_q ? ent_q[0][7:0] : ent_q[0][15:8])
                    : 8'h00;

    // Next-state: fetch grant, byte retire, data return, refetch, then command/end overrides
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        ren_d      = ren_q;
        inflight_d = 1'b0;
        bsel_d     = bsel_q;
        cnt_d      = cnt_q;
        drop_d     = drop_q;
        ent_d      = ent_q;

        if (grant) begin
            idx_d      = idx_q + 8'd1;
            ren_d      = 1'b0;
            inflight_d = 1'b1;
        end

        // Retire happens before the returning data is stored so a freed slot can be refilled at once
        if (state_q == ST_RUN && pw_rstb) begin
            bsel_d = ~bsel_q;
            if (bsel_q) begin
                if (cnt_q != 2'd0) begin
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        ent_d[i] = ent_q[i + 1];
                    end
                    cnt_d = cnt_q - 2'd1;
                end else if (drop_q != 3'd7) begin
                    drop_d = drop_q + 3'd1;
                end
            end
        end

        if (inflight_q) begin
            if (drop_d != 3'd0) begin
                drop_d = drop_d - 3'd1;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (2'(i) == cnt_d) begin
                        ent_d[i] = pal_rdata;
                    end
                end
                cnt_d = cnt_d + 2'd1;
            end
        end

        // Keep live entries (buffered plus in flight, minus those already retired) at the buffer depth
        if (state_q == ST_RUN && !ren_d &&
            ({2'b00, cnt_d} + {3'b000, inflight_d} < 4'(DEPTH) + {1'b0, drop_d})) begin
            ren_d = 1'b1;
        end

        if (pw_end) begin
            state_d    = ST_IDLE;
            ren_d      = 1'b0;
            inflight_d = 1'b0;
            bsel_d     = 1'b0;
            cnt_d      = 2'd0;
            drop_d     = 3'd0;
        end else if (pw_wstb) begin
            if (pw_wcmd) begin
                state_d    = (pw_wdata == CMD_BYTE) ? ST_IDX : ST_IDLE;
                ren_d      = 1'b0;
                inflight_d = 1'b0;
                bsel_d     = 1'b0;
                cnt_d      = 2'd0;
                drop_d     = 3'd0;
            end else if (state_q == ST_IDX) begin
                state_d = ST_RUN;
                idx_d   = pw_wdata;
                ren_d   = 1'b1;
            end
        end
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= 8'h00;
            ren_q      <= 1'b0;
            inflight_q <= 1'b0;
            bsel_q     <= 1'b0;
            cnt_q      <= 2'd0;
            drop_q     <= 3'd0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= 16'h0000;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ren_q      <= ren_d;
            inflight_q <= inflight_d;
            bsel_q     <= bsel_d;
            cnt_q      <= cnt_d;
            drop_q     <= drop_d;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

endmodule

// File: tb/tb_spi_dev_lcdpalrd.sv
// tb/tb_spi_dev_lcdpalrd.sv - randomized self-checking bench for spi_dev_lcdpalrd
module tb_spi_dev_lcdpalrd;

    logic        clk;
    logic        rst_n;
    logic [7:0]  pw_wdata;
    logic        pw_wcmd;
    logic        pw_wstb;
    logic [7:0]  pw_rdata;
    logic        pw_rstb;
    logic        pw_end;
    logic [7:0]  pal_raddr;
    logic        pal_ren;
    logic        pal_rgnt;
    logic [15:0] pal_rdata;

    logic [15:0] pal_mem [256];
    int          gnt_mode;   // 0 immediate grant, 1 never grant, 2 random latency
    int          ren_age;
    int          gnt_lat;
    int          checks;
    int          passed;

    spi_dev_lcdpalrd #(.CMD_BYTE(8'he6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pw_wdata  (pw_wdata),
        .pw_wcmd   (pw_wcmd),
        .pw_wstb   (pw_wstb),
        .pw_rdata  (pw_rdata),
        .pw_rstb   (pw_rstb),
        .pw_end    (pw_end),
        .pal_raddr (pal_raddr),
        .pal_ren   (pal_ren),
        .pal_rgnt  (pal_rgnt),
        .pal_rdata (pal_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign pal_rgnt = pal_ren && (gnt_mode == 0 || (gnt_mode == 2 && ren_age >= gnt_lat));

    // Palette RAM port model: data one cycle after grant, junk otherwise
    always @(posedge clk) begin
        if (pal_ren && pal_rgnt) begin
            pal_rdata <= pal_mem[pal_raddr];
            ren_age   <= 0;
            gnt_lat   <= int'($urandom_range(0, 4));
        end else begin
            pal_rdata <= 16'($urandom);
            ren_age   <= pal_ren ? ren_age + 1 : 0;
        end
    end

    function automatic logic [7:0] exp_byte(input logic [7:0] start, input int k);
        logic [7:0]  i;
        logic [15:0] e;
        i = start + 8'(k / 2);
        e = pal_mem[i];
        return (k % 2 == 0) ? e[15:8] : e[7:0];
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic cmd, input logic [7:0] b);
        pw_wdata = b;
        pw_wcmd  = cmd;
        pw_wstb  = 1'b1;
        @(negedge clk);
        pw_wstb = 1'b0;
        pw_wcmd = 1'b0;
        tick(9);
    endtask

    task automatic read_byte(output logic [7:0] b);
        b       = pw_rdata;
        pw_rstb = 1'b1;
        @(negedge clk);
        pw_rstb = 1'b0;
        tick(9);
    endtask

    task automatic end_txn();
        pw_end = 1'b1;
        @(negedge clk);
        pw_end = 1'b0;
        tick(3);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        checks++; if (pw_rdata !== 8'h00) $display("FAIL reset_rdata: got %h expected 00", pw_rdata); else passed++;
        checks++; if (pal_ren !== 1'b0) $display("FAIL reset_ren: got %b expected 0", pal_ren); else passed++;
        checks++; if (pal_raddr !== 8'h00) $display("FAIL reset_raddr: got %h expected 00", pal_raddr); else passed++;
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_stream();
        logic [7:0] b;
        pal_mem[8'h10] = 16'h1234;
        pal_mem[8'h11] = 16'h5678;
        pal_mem[8'h12] = 16'h9abc;
        gnt_mode = 0;
        send_byte(1'b1, 8'he6);
        pw_wdata = 8'h10;
        pw_wstb  = 1'b1;
        @(negedge clk);
        pw_wstb = 1'b0;
        checks++; if (pal_ren !== 1'b1) $display("FAIL first_ren: got %b expected 1", pal_ren); else passed++;
        checks++; if (pal_raddr !== 8'h10) $display("FAIL first_raddr: got %h expected 10", pal_raddr); else passed++;
        @(negedge clk);
        checks++; if (pw_rdata !== 8'h00) $display("FAIL early_rdata: got %h expected 00", pw_rdata); else passed++;
        @(negedge clk);
        checks++; if (pw_rdata !== 8'h12) $display("FAIL first_msb: got %h expected 12", pw_rdata); else passed++;
        tick(7);
        for (int k = 0; k < 6; k++) begin
            read_byte(b);
            checks++; if (b !== exp_byte(8'h10, k)) $display("FAIL stream_byte%0d: got %h expected %h", k, b, exp_byte(8'h10, k)); else passed++;
        end
        end_txn();
        checks++; if (pw_rdata !== 8'h00) $display("FAIL idle_rdata: got %h expected 00", pw_rdata); else passed++;
    endtask

    task automatic test_wrap();
        logic [7:0] b;
        pal_mem[8'hff] = 16'haaaa;
        pal_mem[8'h00] = 16'h5555;
        gnt_mode = 0;
        send_byte(1'b1, 8'he6);
        pw_wdata = 8'hff;
        pw_wstb  = 1'b1;
        @(negedge clk);
        pw_wstb = 1'b0;
        @(negedge clk);
        checks++; if (pal_raddr !== 8'h00) $display("FAIL wrap_raddr: got %h expected 00", pal_raddr); else passed++;
        tick(8);
        for (int k = 0; k < 4; k++) begin
            read_byte(b);
            checks++; if (b !== exp_byte(8'hff, k)) $display("FAIL wrap_byte%0d: got %h expected %h", k, b, exp_byte(8'hff, k)); else passed++;
        end
        end_txn();
    endtask

    task automatic test_stall();
        logic [7:0] b;
        logic [7:0] s;
        s = 8'($urandom);
        gnt_mode = 1;
        send_byte(1'b1, 8'he6);
        send_byte(1'b0, s);
        for (int c = 0; c < 11; c++) begin
            checks++; if (pal_ren !== 1'b1 || pal_raddr !== s) $display("FAIL stall_hold%0d: got ren=%b addr=%h expected ren=1 addr=%h", c, pal_ren, pal_raddr, s); else passed++;
            @(negedge clk);
        end
        read_byte(b);
        checks++; if (b !== 8'h00) $display("FAIL stall_underflow: got %h expected 00", b); else passed++;
        gnt_mode = 0;
        tick(5);
        for (int k = 1; k < 4; k++) begin
            read_byte(b);
            checks++; if (b !== exp_byte(s, k)) $display("FAIL stall_byte%0d: got %h expected %h", k, b, exp_byte(s, k)); else passed++;
        end
        end_txn();
    endtask

    task automatic test_end_cancel();
        logic [7:0] b;
        gnt_mode = 1;
        send_byte(1'b1, 8'he6);
        send_byte(1'b0, 8'h40);
        end_txn();
        checks++; if (pal_ren !== 1'b0) $display("FAIL end_drop_ren: got %b expected 0", pal_ren); else passed++;
        send_byte(1'b1, 8'he6);
        send_byte(1'b0, 8'h50);
        pw_end   = 1'b1;
        gnt_mode = 0;
        @(negedge clk);
        pw_end = 1'b0;
        checks++; if (pal_ren !== 1'b0) $display("FAIL end_grant_ren: got %b expected 0", pal_ren); else passed++;
        checks++; if (pw_rdata !== 8'h00) $display("FAIL end_grant_rdata: got %h expected 00", pw_rdata); else passed++;
        @(negedge clk);
        checks++; if (pw_rdata !== 8'h00) $display("FAIL end_discard_rdata: got %h expected 00", pw_rdata); else passed++;
        tick(3);
        gnt_mode = 1;
        send_byte(1'b0, 8'h60);
        checks++; if (pal_ren !== 1'b0) $display("FAIL end_idle_ren: got %b expected 0", pal_ren); else passed++;
        read_byte(b);
        checks++; if (b !== 8'h00) $display("FAIL end_idle_read: got %h expected 00", b); else passed++;
        gnt_mode = 0;
    endtask

    task automatic test_bad_cmd();
        logic [7:0] b;
        gnt_mode = 1;
        send_byte(1'b1, 8'he4);
        send_byte(1'b0, 8'h10);
        checks++; if (pal_ren !== 1'b0) $display("FAIL badcmd_ren: got %b expected 0", pal_ren); else passed++;
        read_byte(b);
        checks++; if (b !== 8'h00) $display("FAIL badcmd_read: got %h expected 00", b); else passed++;
        end_txn();
        gnt_mode = 0;
    endtask

    task automatic test_restart();
        logic [7:0] b;
        logic [7:0] a;
        logic [7:0] n;
        a = 8'($urandom);
        n = 8'($urandom);
        gnt_mode = 0;
        send_byte(1'b1, 8'he6);
        send_byte(1'b0, a);
        for (int k = 0; k < 3; k++) begin
            read_byte(b);
            checks++; if (b !== exp_byte(a, k)) $display("FAIL restart_pre%0d: got %h expected %h", k, b, exp_byte(a, k)); else passed++;
        end
        send_byte(1'b1, 8'he6);
        send_byte(1'b0, n);
        for (int k = 0; k < 4; k++) begin
            read_byte(b);
            checks++; if (b !== exp_byte(n, k)) $display("FAIL restart_post%0d: got %h expected %h", k, b, exp_byte(n, k)); else passed++;
        end
        end_txn();
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic [7:0] s;
        int         len;
        gnt_mode = 2;
        for (int t = 0; t < 5; t++) begin
            s   = 8'($urandom);
            len = int'($urandom_range(1, 10));
            send_byte(1'b1, 8'he6);
            send_byte(1'b0, s);
            for (int k = 0; k < len; k++) begin
                read_byte(b);
                checks++; if (b !== exp_byte(s, k)) $display("FAIL random_t%0d_b%0d: got %h expected %h", t, k, b, exp_byte(s, k)); else passed++;
            end
            end_txn();
        end
        gnt_mode = 0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        logic [7:0] s;
        s = 8'($urandom);
        pal_mem[8'h00] = 16'hc3a5;
        gnt_mode = 0;
        send_byte(1'b1, 8'he6);
        send_byte(1'b0, s);
        read_byte(b);
        gnt_mode = 1;
        read_byte(b);
        checks++; if (pal_ren !== 1'b1) $display("FAIL midrst_pre_ren: got %b expected 1", pal_ren); else passed++;
        rst_n = 1'b0;
        #1;
        checks++; if (pal_ren !== 1'b0) $display("FAIL midrst_ren: got %b expected 0", pal_ren); else passed++;
        checks++; if (pw_rdata !== 8'h00) $display("FAIL midrst_rdata: got %h expected 00", pw_rdata); else passed++;
        checks++; if (pal_raddr !== 8'h00) $display("FAIL midrst_raddr: got %h expected 00", pal_raddr); else passed++;
        @(negedge clk);
        rst_n    = 1'b1;
        gnt_mode = 0;
        tick(2);
        checks++; if (pw_rdata !== 8'h00) $display("FAIL postrst_rdata: got %h expected 00", pw_rdata); else passed++;
        send_byte(1'b1, 8'he6);
        send_byte(1'b0, 8'h00);
        for (int k = 0; k < 2; k++) begin
            read_byte(b);
            checks++; if (b !== exp_byte(8'h00, k)) $display("FAIL postrst_byte%0d: got %h expected %h", k, b, exp_byte(8'h00, k)); else passed++;
        end
        end_txn();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        passed   = 0;
        gnt_mode = 0;
        rst_n    = 1'b0;
        pw_wdata = 8'h00;
        pw_wcmd  = 1'b0;
        pw_wstb  = 1'b0;
        pw_rstb  = 1'b0;
        pw_end   = 1'b0;
        for (int i = 0; i < 256; i++) begin
            pal_mem[i] = 16'($urandom);
        end
        @(negedge clk);
        test_reset();
        test_stream();
        test_wrap();
        test_stall();
        test_end_cancel();
        test_bad_cmd();
        test_restart();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
